// File: rtl/simpson_pkg.sv
// simpson_pkg: shared types and constants for the Simpson operand-entry driver.
//   entry_state_e : sequencer states
//   NUM_OPS/OP_*  : operand count and send-order slot indices
//   DEF_*         : default data width and click timing
//   timer_width() : phase-timer width sized to the longest phase
package simpson_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StPress  = 3'd2,
        StGap    = 3'd3,
        StSettle = 3'd4,
        StReport = 3'd5
    } entry_state_e;

    localparam int unsigned NUM_OPS = 6;
    localparam int unsigned IDX_W   = 3;

    // Send order of the operand slots.
    localparam int unsigned OP_A0 = 0;
    localparam int unsigned OP_A1 = 1;
    localparam int unsigned OP_A2 = 2;
    localparam int unsigned OP_A3 = 3;
    localparam int unsigned OP_LO = 4;
    localparam int unsigned OP_HI = 5;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_SETUP_CYC  = 3;
    localparam int unsigned DEF_PRESS_CYC  = 14;
    localparam int unsigned DEF_GAP_CYC    = 6;
    localparam int unsigned DEF_SETTLE_CYC = 50;

    // The timer is loaded with N-1, so clog2 of the largest N always fits; keep at least 1 bit.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/simpson_phase_timer.sv
// simpson_phase_timer: loadable down-counter that times one sequencer phase.
//   clk       : system clock
//   cpu_reset : asynchronous active-low reset (count cleared)
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : phase length minus one
//   done      : count has reached zero; the phase ends on this cycle
module simpson_phase_timer #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             cpu_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/simpson_entry_driver.sv
// simpson_entry_driver: replays one operand set into the Simpson fsm as six sw/btn clicks
// (a0, a1, a2, a3, lo, hi), waits a settle time, then samples and reports the fsm result.
//   clk, cpu_reset       : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand-set handshake; in_ready is high only in idle
//   in_a0..in_a3         : polynomial coefficients
//   in_lo, in_hi         : integration bounds
//   sw, btn              : switch value and button level driven to the fsm
//   fsm_result, fsm_err  : fsm outputs, sampled on the last settle cycle
//   res_valid            : one-cycle pulse qualifying res_data/res_err
//   res_data, res_err    : captured result and error flag (held until next capture)
//   busy                 : high whenever not idle
// Optional build macro SIMPSON_ENTRY_ABORT_EN adds input abort: cancels a running sequence
// and reports res_err=1, res_data=0.
module simpson_entry_driver
    import simpson_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned PRESS_CYC  = DEF_PRESS_CYC,
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              cpu_reset,
`ifdef SIMPSON_ENTRY_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a0,
    input  logic [DATA_W-1:0] in_a1,
    input  logic [DATA_W-1:0] in_a2,
    input  logic [DATA_W-1:0] in_a3,
    input  logic [DATA_W-1:0] in_lo,
    input  logic [DATA_W-1:0] in_hi,
    output logic [DATA_W-1:0] sw,
    output logic              btn,
    input  logic [DATA_W-1:0] fsm_result,
    input  logic              fsm_err,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              busy
);

    if (SETUP_CYC < 1 || PRESS_CYC < 1 || GAP_CYC < 1 || SETTLE_CYC < 1) begin : gen_bad_timing
        $error("simpson_entry_driver: all phase lengths must be at least 1 cycle");
    end

    localparam int unsigned TIMER_W = timer_width(SETUP_CYC, PRESS_CYC, GAP_CYC, SETTLE_CYC);

    localparam logic [TIMER_W-1:0] SETUP_LD  = TIMER_W'(SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] PRESS_LD  = TIMER_W'(PRESS_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LD    = TIMER_W'(GAP_CYC - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYC - 1);

    entry_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_next;
    logic [DATA_W-1:0] sw_q, sw_d;
    logic              btn_q, btn_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_err_q, res_err_d;
    logic [DATA_W-1:0] op_q [NUM_OPS];

    logic               accept;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_done;

    simpson_phase_timer #(
        .WIDTH (TIMER_W)
    ) u_phase_timer (
        .clk       (clk),
        .cpu_reset (cpu_reset),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .done      (tmr_done)
    );

    assign idx_next = idx_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sw_d         = sw_q;
        btn_d        = btn_q;
        res_valid_d  = 1'b0;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        accept       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // a0 goes straight onto sw; the hold register catches the full set.
                    accept       = 1'b1;
                    idx_d        = '0;
                    sw_d         = in_a0;
                    btn_d        = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LD;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                if (tmr_done) begin
                    btn_d        = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = PRESS_LD;
                    state_d      = StPress;
                end
            end
            StPress: begin
                if (tmr_done) begin
                    btn_d        = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = GAP_LD;
                    state_d      = StGap;
                end
            end
            StGap: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (idx_q == IDX_W'(OP_HI)) begin
                        tmr_load_val = SETTLE_LD;
                        state_d      = StSettle;
                    end else begin
                        // sw only moves here, with btn already low for the whole gap.
                        idx_d        = idx_next;
                        sw_d         = op_q[idx_next];
                        tmr_load_val = SETUP_LD;
                        state_d      = StSetup;
                    end
                end
            end
            StSettle: begin
                if (tmr_done) begin
                    res_data_d  = fsm_result;
                    res_err_d   = fsm_err;
                    res_valid_d = 1'b1;
                    state_d     = StReport;
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef SIMPSON_ENTRY_ABORT_EN
        if (abort && (state_q != StIdle) && (state_q != StReport)) begin
            state_d     = StIdle;
            idx_d       = '0;
            sw_d        = '0;
            btn_d       = 1'b0;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = 1'b1;
            tmr_load    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            sw_q        <= '0;
            btn_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sw_q        <= sw_d;
            btn_q       <= btn_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                op_q[i] <= '0;
            end
        end else if (accept) begin
            op_q[OP_A0] <= in_a0;
            op_q[OP_A1] <= in_a1;
            op_q[OP_A2] <= in_a2;
            op_q[OP_A3] <= in_a3;
            op_q[OP_LO] <= in_lo;
            op_q[OP_HI] <= in_hi;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign sw        = sw_q;
    assign btn       = btn_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_simpson_entry_driver.sv
// tb_simpson_entry_driver: scoreboard bench for simpson_entry_driver with default timing.
// Expected results are queued at accept time and popped when res_valid pulses.
module tb_simpson_entry_driver;

    localparam int DATA_W  = 16;
    localparam int CLICK   = 23;   // setup + press + gap
    localparam int SETUP   = 3;
    localparam int PRESS   = 14;
    localparam int LATENCY = 188;

    typedef logic [DATA_W-1:0] ops_t [6];
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              cpu_reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a0 = '0, in_a1 = '0, in_a2 = '0, in_a3 = '0, in_lo = '0, in_hi = '0;
    logic [DATA_W-1:0] sw;
    logic              btn;
    logic [DATA_W-1:0] fsm_result = '0;
    logic              fsm_err = 1'b0;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic              busy;
`ifdef SIMPSON_ENTRY_ABORT_EN
    logic              abort = 1'b0;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    logic [DATA_W-1:0] rec_sw [6];
    int                rec_rise [6];
    int                rec_fall [6];
    int                rec_n, rec_lat, rec_busy_bad, rec_sw_bad;

    simpson_entry_driver u_dut (
        .clk        (clk),
        .cpu_reset  (cpu_reset),
`ifdef SIMPSON_ENTRY_ABORT_EN
        .abort      (abort),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a0      (in_a0),
        .in_a1      (in_a1),
        .in_a2      (in_a2),
        .in_a3      (in_a3),
        .in_lo      (in_lo),
        .in_hi      (in_hi),
        .sw         (sw),
        .btn        (btn),
        .fsm_result (fsm_result),
        .fsm_err    (fsm_err),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_err    (res_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops(input ops_t ops);
        in_a0 = ops[0]; in_a1 = ops[1]; in_a2 = ops[2];
        in_a3 = ops[3]; in_lo = ops[4]; in_hi = ops[5];
    endtask

    // Offer a set, wait for the accept edge, queue its expected result.
    task automatic start_set(input ops_t ops, input logic [DATA_W-1:0] res_val,
                             input logic res_e, input bit keep_valid);
        int   w;
        exp_t e;
        w = 0;
        while (in_ready !== 1'b1 && w < 300) begin
            step();
            w++;
        end
        if (w >= 300) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: in_ready=%b after %0d cycles, required 1", in_ready, w);
        end
        drive_ops(ops);
        in_valid = 1'b1;
        step();
        e.data = res_val;
        e.err  = res_e;
        sb_q.push_back(e);
        if (!keep_valid) begin
            in_valid = 1'b0;
            in_a0 = DATA_W'($urandom); in_a1 = DATA_W'($urandom); in_a2 = DATA_W'($urandom);
            in_a3 = DATA_W'($urandom); in_lo = DATA_W'($urandom); in_hi = DATA_W'($urandom);
        end
    endtask

    // Follow a running sequence to its res_valid, recording clicks; pops the scoreboard.
    task automatic watch_run(input logic [DATA_W-1:0] res_val, input logic res_e);
        logic              prev_btn;
        logic [DATA_W-1:0] prev_sw;
        int                c;
        bit                done;
        exp_t              e;
        for (int k = 0; k < 6; k++) begin
            rec_sw[k] = 'x; rec_rise[k] = -1; rec_fall[k] = -1;
        end
        rec_n = 0; rec_lat = -1; rec_busy_bad = 0; rec_sw_bad = 0;
        // Decoy values until well after the last click; only the settle sample may see them.
        fsm_result = 16'hDEAD;
        fsm_err    = ~res_e;
        prev_btn   = btn;
        prev_sw    = sw;
        c = 0;
        done = 0;
        while (!done && c < 400) begin
            step();
            c++;
            if (c == 140) begin
                fsm_result = res_val;
                fsm_err    = res_e;
            end
            if (busy !== 1'b1 || in_ready !== 1'b0) rec_busy_bad++;
            if (sw !== prev_sw && (btn === 1'b1 || prev_btn === 1'b1)) rec_sw_bad++;
            if (btn === 1'b1 && prev_btn === 1'b0 && rec_n < 6) begin
                rec_sw[rec_n]   = sw;
                rec_rise[rec_n] = c;
            end
            if (btn === 1'b0 && prev_btn === 1'b1) begin
                if (rec_n < 6) rec_fall[rec_n] = c;
                rec_n++;
            end
            prev_btn = btn;
            prev_sw  = sw;
            if (res_valid === 1'b1) begin
                rec_lat = c;
                done = 1;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: res_valid with data=%0d but nothing pending",
                             res_data);
                end else begin
                    e = sb_q.pop_front();
                    if (res_data !== e.data || res_err !== e.err) begin
                        errors++;
                        $display("FAIL result: got data=%0d err=%b, required data=%0d err=%b",
                                 res_data, res_err, e.data, e.err);
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no res_valid within 400 cycles of accept");
        end
        step();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: res_valid=%b one cycle after report, required 0", res_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_report: in_ready=%b, required 1", in_ready);
        end
        checks++;
        if (res_data !== res_val) begin
            errors++;
            $display("FAIL res_hold: res_data=%0d after pulse, required %0d", res_data, res_val);
        end
    endtask

    task automatic test_reset();
        cpu_reset = 1'b0;
        repeat (2) step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
        checks++;
        if (sw !== '0 || btn !== 1'b0) begin
            errors++;
            $display("FAIL reset_sw_btn: sw=%0d btn=%b, required 0 0", sw, btn);
        end
        checks++;
        if (res_valid !== 1'b0 || res_data !== '0 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_res: valid=%b data=%0d err=%b, required 0 0 0",
                     res_valid, res_data, res_err);
        end
        cpu_reset = 1'b1;
        step();
    endtask

    task automatic test_sequence();
        ops_t ops = '{16'd7, 16'd0, 16'd0, 16'd0, 16'd7, 16'd15};
        start_set(ops, 16'd52, 1'b0, 1'b0);
        watch_run(16'd52, 1'b0);
        checks++;
        if (rec_n !== 6) begin
            errors++;
            $display("FAIL click_count: %0d btn pulses, required 6", rec_n);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rec_sw[k] !== ops[k]) begin
                errors++;
                $display("FAIL click_value[%0d]: sw=%0d, required %0d", k, rec_sw[k], ops[k]);
            end
            checks++;
            if (rec_rise[k] != CLICK * k + SETUP || rec_fall[k] != CLICK * k + SETUP + PRESS) begin
                errors++;
                $display("FAIL click_timing[%0d]: rise=%0d fall=%0d, required %0d %0d", k,
                         rec_rise[k], rec_fall[k], CLICK * k + SETUP, CLICK * k + SETUP + PRESS);
            end
        end
        checks++;
        if (rec_lat != LATENCY) begin
            errors++;
            $display("FAIL latency: res_valid %0d cycles after accept, required %0d",
                     rec_lat, LATENCY);
        end
        checks++;
        if (rec_busy_bad != 0) begin
            errors++;
            $display("FAIL busy_run: %0d cycles with busy=0 or in_ready=1, required 0",
                     rec_busy_bad);
        end
    endtask

    task automatic test_result_value();
        ops_t ops = '{16'd4, 16'd10, 16'd0, 16'd2, 16'd5, 16'd12};
        start_set(ops, 16'd10681, 1'b0, 1'b0);
        watch_run(16'd10681, 1'b0);
        checks++;
        if (rec_sw_bad != 0) begin
            errors++;
            $display("FAIL sw_while_btn: %0d sw changes with btn high, required 0", rec_sw_bad);
        end
        checks++;
        if (rec_sw[3] !== ops[3] || rec_sw[5] !== ops[5]) begin
            errors++;
            $display("FAIL click_values: a3=%0d hi=%0d, required %0d %0d",
                     rec_sw[3], rec_sw[5], ops[3], ops[5]);
        end
    endtask

    task automatic test_error_flag();
        ops_t ops = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd5, 16'd4};
        start_set(ops, 16'd300, 1'b1, 1'b0);
        watch_run(16'd300, 1'b1);
        checks++;
        if (res_err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: res_err=%b after report, required 1", res_err);
        end
    endtask

    task automatic test_back_to_back();
        ops_t set1 = '{16'd7, 16'd0, 16'd0, 16'd0, 16'd7, 16'd15};
        ops_t set2 = '{16'd1, 16'd3, 16'd0, 16'd0, 16'd2, 16'd8};
        start_set(set1, 16'd52, 1'b0, 1'b1);
        drive_ops(set2);   // in_valid stays high through the first run
        watch_run(16'd52, 1'b0);
        checks++;
        if (rec_sw[1] !== set1[1] || rec_sw[5] !== set1[5]) begin
            errors++;
            $display("FAIL ignore_midrun: a1=%0d hi=%0d, required %0d %0d",
                     rec_sw[1], rec_sw[5], set1[1], set1[5]);
        end
        checks++;
        if (rec_busy_bad != 0) begin
            errors++;
            $display("FAIL ready_while_busy: %0d bad cycles, required 0", rec_busy_bad);
        end
        start_set(set2, 16'd93, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || sw !== set2[0]) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b sw=%0d, required 1 %0d", busy, sw, set2[0]);
        end
        watch_run(16'd93, 1'b0);
        checks++;
        if (rec_lat != LATENCY || rec_sw[5] !== set2[5]) begin
            errors++;
            $display("FAIL b2b_second: latency=%0d hi=%0d, required %0d %0d",
                     rec_lat, rec_sw[5], LATENCY, set2[5]);
        end
    endtask

    task automatic test_reset_mid_run();
        ops_t ops   = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4};
        ops_t fresh = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd1, 16'd9};
        int   stray;
        start_set(ops, 16'd11, 1'b0, 1'b0);
        // Third press spans cycles 49..62 after accept.
        repeat (55) step();
        checks++;
        if (btn !== 1'b1 || sw !== ops[2]) begin
            errors++;
            $display("FAIL third_press: btn=%b sw=%0d, required 1 %0d", btn, sw, ops[2]);
        end
        #2;
        cpu_reset = 1'b0;
        #1;
        checks++;
        if (btn !== 1'b0 || sw !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: btn=%b sw=%0d in_ready=%b, required 0 0 1",
                     btn, sw, in_ready);
        end
        repeat (3) step();
        cpu_reset = 1'b1;
        sb_q.delete();
        stray = 0;
        repeat (200) begin
            step();
            if (res_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard: %0d res_valid pulses, in_ready=%b, required 0 1",
                     stray, in_ready);
        end
        start_set(fresh, 16'd777, 1'b0, 1'b0);
        watch_run(16'd777, 1'b0);
        checks++;
        if (rec_lat != LATENCY || rec_sw[0] !== fresh[0]) begin
            errors++;
            $display("FAIL after_reset: latency=%0d a0=%0d, required %0d %0d",
                     rec_lat, rec_sw[0], LATENCY, fresh[0]);
        end
    endtask

`ifdef SIMPSON_ENTRY_ABORT_EN
    task automatic test_abort();
        ops_t ops = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2};
        exp_t e;
        start_set(ops, 16'd52, 1'b0, 1'b0);
        // Second gap spans cycles 40..45 after accept.
        repeat (42) step();
        void'(sb_q.pop_front());
        e.data = '0;
        e.err  = 1'b1;
        sb_q.push_back(e);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (btn !== 1'b0 || sw !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: btn=%b sw=%0d in_ready=%b, required 0 0 1",
                     btn, sw, in_ready);
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_valid: res_valid=%b, required 1", res_valid);
        end else begin
            e = sb_q.pop_front();
            if (res_data !== e.data || res_err !== e.err) begin
                errors++;
                $display("FAIL abort_result: data=%0d err=%b, required %0d %b",
                         res_data, res_err, e.data, e.err);
            end
        end
        abort = 1'b1;   // ignored in idle
        step();
        abort = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: res_valid=%b busy=%b, required 0 0", res_valid, busy);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_sequence();
        test_result_value();
        test_error_flag();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SIMPSON_ENTRY_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
